brush_writer: RTL and testbench

- Avalon-MM write master that paints a square "brush" of particle cells into a screen buffer in SDRAM.
- It is the write-side counterpart of vga_render, which reads that buffer for display.
- On a start pulse it latches the brush centre, radius and particle type. It clips the square to the 640x480 field, then issues one byte-enabled 32-bit write per word touched, row by row.
- Buffer layout: one byte per cell, row-major, 640 bytes per row. Cell byte = {6'b0, type}.

---
 rtl/brush_writer_if.sv | 25 ++
 rtl/brush_writer.sv | 156 +++++++++++++++
 tb/tb_brush_writer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/brush_writer_if.sv
// Avalon-MM write-only bus between brush_writer and the SDRAM controller.
// Byte-enabled 32-bit writes, stalled by waitrequest.
interface brush_writer_if;
    logic [23:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;

    modport master (
        output mem_address,
        output mem_write,
        output mem_writedata,
        output mem_byteenable,
        input  mem_waitrequest
    );

    modport slave (
        input  mem_address,
        input  mem_write,
        input  mem_writedata,
        input  mem_byteenable,
        output mem_waitrequest
    );
endinterface

// File: rtl/brush_writer.sv
// Paints a clipped square brush of particle cells into a byte-per-cell screen
// buffer, one byte-enabled 32-bit Avalon write per word touched, row by row.
module brush_writer #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int ROW_BYTES = 640
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 target,
    input  logic [31:0]          screen_a_ptr,
    input  logic [31:0]          screen_b_ptr,
    input  logic [10:0]          write_x,
    input  logic [9:0]           write_y,
    input  logic [1:0]           write_t,
    input  logic [1:0]           write_radius,
    brush_writer_if.master       mem,
    output logic                 busy,
    output logic                 done
);

    localparam logic [10:0] WIDTH_L     = 11'(WIDTH);
    localparam logic [10:0] HEIGHT_L    = 11'(HEIGHT);
    localparam logic [9:0]  XMAX_L      = 10'(WIDTH - 1);
    localparam logic [9:0]  YMAX_L      = 10'(HEIGHT - 1);
    localparam logic [23:0] ROW_BYTES_L = 24'(ROW_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLIP,
        S_ROW,
        S_WRITE,
        S_FIN
    } state_t;

    state_t      state_q, state_d;

    logic [9:0]  cx_q, cy_q;
    logic [1:0]  r_q;
    logic [1:0]  type_q;
    logic [23:0] base_q;
    logic [9:0]  x0_q, x1_q, y1_q, row_q;
    logic [7:0]  word_q;
    logic [23:0] rowbase_q;

    logic [3:0]  be_w;
    logic [9:0]  cell_w;
    logic        last_word_w;
    logic        accept_w;

    logic        unused_ok;
    assign unused_ok = ^{screen_a_ptr[31:24], screen_b_ptr[31:24], write_x[0]};

    // Guarded subtraction so the low bound saturates at 0 instead of wrapping.
    function automatic logic [9:0] clip_lo(input logic [9:0] c, input logic [1:0] r);
        clip_lo = (c < {8'd0, r}) ? 10'd0 : c - {8'd0, r};
    endfunction

    function automatic logic [9:0] clip_hi(input logic [9:0] c, input logic [1:0] r,
                                           input logic [9:0] lim);
        logic [10:0] s;
        s       = {1'b0, c} + {9'd0, r};
        clip_hi = (s > {1'b0, lim}) ? lim : s[9:0];
    endfunction

    always_comb begin
        be_w   = '0;
        cell_w = '0;
        for (int i = 0; i < 4; i++) begin
            cell_w  = {word_q, 2'b00} | 10'(i);
            be_w[i] = (cell_w >= x0_q) && (cell_w <= x1_q);
        end
    end

    assign last_word_w = ({1'b0, word_q, 2'b00} + 11'd3) >= {1'b0, x1_q};
    assign accept_w    = (state_q == S_WRITE) && !mem.mem_waitrequest;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d            = state_q;
        busy               = 1'b0;
        done               = 1'b0;
        mem.mem_write      = 1'b0;
        mem.mem_address    = '0;
        mem.mem_writedata  = '0;
        mem.mem_byteenable = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLIP;
            end
            S_CLIP: begin
                busy = 1'b1;
                if ({1'b0, cx_q} >= WIDTH_L || {1'b0, cy_q} >= HEIGHT_L) state_d = S_FIN;
                else                                                     state_d = S_ROW;
            end
            S_ROW: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy               = 1'b1;
                mem.mem_write      = 1'b1;
                mem.mem_address    = rowbase_q + {14'd0, word_q, 2'b00};
                mem.mem_writedata  = {4{6'b0, type_q}};
                mem.mem_byteenable = be_w;
                if (!mem.mem_waitrequest && last_word_w) begin
                    if (row_q < y1_q) state_d = S_ROW;
                    else              state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers carry no reset; each is loaded before it is consumed.
    always_ff @(posedge clock) begin
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_q   <= write_x[10:1];
                    cy_q   <= write_y;
                    r_q    <= write_radius;
                    type_q <= write_t;
                    base_q <= target ? screen_b_ptr[23:0] : screen_a_ptr[23:0];
                end
            end
            S_CLIP: begin
                x0_q  <= clip_lo(cx_q, r_q);
                x1_q  <= clip_hi(cx_q, r_q, XMAX_L);
                row_q <= clip_lo(cy_q, r_q);
                y1_q  <= clip_hi(cy_q, r_q, YMAX_L);
            end
            S_ROW: begin
                word_q    <= x0_q[9:2];
                rowbase_q <= base_q + 24'(row_q) * ROW_BYTES_L;
            end
            S_WRITE: begin
                if (accept_w) begin
                    if (!last_word_w)       word_q <= word_q + 8'd1;
                    else if (row_q < y1_q)  row_q  <= row_q + 10'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_brush_writer.sv
// Directed bench for brush_writer: a square-painting model predicts every
// accepted Avalon write, and a negedge monitor compares the bus against it.
module tb_brush_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        target = 1'b0;
    logic [31:0] screen_a_ptr = 32'h0;
    logic [31:0] screen_b_ptr = 32'h0;
    logic [10:0] write_x = '0;
    logic [9:0]  write_y = '0;
    logic [1:0]  write_t = '0;
    logic [1:0]  write_radius = '0;
    logic        busy, done;

    brush_writer_if bus ();

    brush_writer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .target       (target),
        .screen_a_ptr (screen_a_ptr),
        .screen_b_ptr (screen_b_ptr),
        .write_x      (write_x),
        .write_y      (write_y),
        .write_t      (write_t),
        .write_radius (write_radius),
        .mem          (bus.master),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [23:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  acc_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Model: every in-field cell of the square, grouped into the 32-bit words it occupies.
    task automatic build_model(input int cx, input int cy, input int r, input int t,
                               input logic [23:0] base);
        int lo, hi;
        wr_t w;
        exp_q.delete();
        if (cx >= 640 || cy >= 480) return;
        lo = (cx - r < 0) ? 0 : cx - r;
        hi = (cx + r > 639) ? 639 : cx + r;
        for (int y = cy - r; y <= cy + r; y++) begin
            if (y < 0 || y >= 480) continue;
            for (int wd = lo / 4; wd <= hi / 4; wd++) begin
                w.be = '0;
                for (int i = 0; i < 4; i++)
                    if (4 * wd + i >= lo && 4 * wd + i <= hi) w.be[i] = 1'b1;
                w.addr = 24'(int'(base) + y * 640 + 4 * wd);
                w.data = {4{6'b0, 2'(t)}};
                exp_q.push_back(w);
            end
        end
    endtask

    logic        in_stall = 1'b0;
    logic        pending_done = 1'b0;
    logic [23:0] held_addr;
    logic [3:0]  held_be;
    logic [31:0] held_data;

    always @(negedge clock) begin
        if (reset) begin
            in_stall     = 1'b0;
            pending_done = 1'b0;
        end else begin
            if (pending_done) begin
                check("done_after_last", 32'(done), 32'd1);
                pending_done = 1'b0;
            end
            if (done) check("done_with_writes_left", exp_q.size(), 0);
            if (bus.mem_write) begin
                if (in_stall) begin
                    check("stall_addr", 32'(bus.mem_address), 32'(held_addr));
                    check("stall_be", 32'(bus.mem_byteenable), 32'(held_be));
                    check("stall_data", bus.mem_writedata, held_data);
                end
                held_addr = bus.mem_address;
                held_be   = bus.mem_byteenable;
                held_data = bus.mem_writedata;
                in_stall  = bus.mem_waitrequest;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.mem_address), 32'hFFFFFFFF);
                end else if (!bus.mem_waitrequest) begin
                    check("wr_addr", 32'(bus.mem_address), 32'(exp_q[0].addr));
                    check("wr_be", 32'(bus.mem_byteenable), 32'(exp_q[0].be));
                    check("wr_data", bus.mem_writedata, exp_q[0].data);
                    void'(exp_q.pop_front());
                    acc_cnt++;
                    if (exp_q.size() == 0) pending_done = 1'b1;
                end
            end else begin
                in_stall = 1'b0;
            end
        end
    end

    task automatic drive_start(input int cx, input int cy, input int r, input int t,
                               input logic tgt);
        @(posedge clock);
        #1;
        write_x      = 11'(cx * 2);
        write_y      = 10'(cy);
        write_radius = 2'(r);
        write_t      = 2'(t);
        target       = tgt;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_brush(input int cx, input int cy, input int r, input int t,
                             input logic tgt);
        int n_exp, lat, dlat;
        bit got_done;
        build_model(cx, cy, r, t, tgt ? screen_b_ptr[23:0] : screen_a_ptr[23:0]);
        n_exp    = exp_q.size();
        acc_cnt  = 0;
        lat      = -1;
        dlat     = -1;
        got_done = 0;
        drive_start(cx, cy, r, t, tgt);
        for (int c = 1; c <= 300 && !got_done; c++) begin
            @(negedge clock);
            if (lat < 0 && bus.mem_write) lat = c;
            if (done) begin
                got_done = 1;
                dlat     = c;
                check("busy_low_at_done", 32'(busy), 32'd0);
            end
        end
        check("done_seen", 32'(got_done), 32'd1);
        if (n_exp > 0) check("first_write_latency", lat, 3);
        else           check("done_latency_nowrite", dlat, 2);
        repeat (4) @(negedge clock);
        check("writes_remaining", exp_q.size(), 0);
        check("write_count", acc_cnt, n_exp);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_waitrequest = 1'b0;
        screen_a_ptr = 32'h0010_0000;
        screen_b_ptr = 32'h0020_0000;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_write", 32'(bus.mem_write), 32'd0);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_be", 32'(bus.mem_byteenable), 32'd0);
        check("rst_data", bus.mem_writedata, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Pin the model to hand-computed values.
        build_model(5, 2, 0, 1, 24'h100000);
        check("model_single_n", exp_q.size(), 1);
        check("model_single_addr", 32'(exp_q[0].addr), 32'h100504);
        check("model_single_be", 32'(exp_q[0].be), 32'b0010);
        check("model_single_data", exp_q[0].data, 32'h01010101);
        build_model(5, 10, 3, 2, 24'h200000);
        check("model_full_n", exp_q.size(), 21);
        check("model_full_first", 32'(exp_q[0].addr), 32'h201180);
        check("model_full_last", 32'(exp_q[20].addr), 32'h202088);
        check("model_full_be0", 32'(exp_q[0].be), 32'b1100);
        check("model_full_be1", 32'(exp_q[1].be), 32'b1111);
        check("model_full_be2", 32'(exp_q[2].be), 32'b0001);
        build_model(0, 0, 2, 3, 24'h0);
        check("model_corner_n", exp_q.size(), 3);
        check("model_corner_off", 32'(exp_q[2].addr), 32'd1280);
        check("model_corner_be", 32'(exp_q[1].be), 32'b0111);
        build_model(639, 479, 1, 1, 24'h100000);
        check("model_rb_n", exp_q.size(), 2);
        check("model_rb_addr", 32'(exp_q[0].addr), 32'h100000 + 478 * 640 + 636);
        check("model_rb_be", 32'(exp_q[1].be), 32'b1100);
        exp_q.delete();

        run_brush(5, 2, 0, 1, 1'b0);
        run_brush(5, 10, 3, 2, 1'b1);
        run_brush(0, 0, 2, 3, 1'b0);
        run_brush(639, 479, 1, 1, 1'b0);
        run_brush(640, 10, 1, 1, 1'b0);
        run_brush(100, 480, 2, 2, 1'b1);
        run_brush(1, 300, 3, 1, 1'b1);

        // Stall the first write for 5 edges and re-pulse start while busy.
        bus.mem_waitrequest = 1'b1;
        fork
            run_brush(0, 0, 2, 3, 1'b0);
            begin
                for (int k = 0; k < 50 && !bus.mem_write; k++) @(negedge clock);
                repeat (2) @(posedge clock);
                #1 start = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
                repeat (2) @(posedge clock);
                #1 bus.mem_waitrequest = 1'b0;
            end
        join

        // Reset during the second write of the full brush.
        build_model(5, 10, 3, 2, 24'h200000);
        acc_cnt = 0;
        drive_start(5, 10, 3, 2, 1'b1);
        for (int k = 0; k < 50 && !(acc_cnt == 1 && bus.mem_write); k++) @(negedge clock);
        check("reached_second_write", acc_cnt, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_write", 32'(bus.mem_write), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_addr", 32'(bus.mem_address), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_idle_write", 32'(bus.mem_write), 32'd0);
        run_brush(5, 2, 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
